// File: rtl/disp_pkg.sv
// Shared definitions for the score display controller.
//
// Contents:
//   NUM_DIGITS    number of multiplexed seven-segment digits
//   MAX_SCORE     largest displayable score; larger inputs saturate to it
//   SEG_BLANK     segment pattern with every segment dark
//   SEG_0..SEG_9  active-low segment patterns, bit order {a,b,c,d,e,f,g}
//   conv_state_e  state encoding of the binary-to-BCD converter
//   seg_decode()  BCD nibble to segment pattern; non-decimal nibbles go dark
//   saturate()    clamps a 14-bit binary score to MAX_SCORE
package disp_pkg;

    localparam int          NUM_DIGITS = 4;
    localparam logic [13:0] MAX_SCORE  = 14'd9999;

    localparam logic [6:0] SEG_BLANK = 7'b111_1111;

    localparam logic [6:0] SEG_0 = 7'b000_0001;
    localparam logic [6:0] SEG_1 = 7'b100_1111;
    localparam logic [6:0] SEG_2 = 7'b001_0010;
    localparam logic [6:0] SEG_3 = 7'b000_0110;
    localparam logic [6:0] SEG_4 = 7'b100_1100;
    localparam logic [6:0] SEG_5 = 7'b010_0100;
    localparam logic [6:0] SEG_6 = 7'b010_0000;
    localparam logic [6:0] SEG_7 = 7'b000_1111;
    localparam logic [6:0] SEG_8 = 7'b000_0000;
    localparam logic [6:0] SEG_9 = 7'b000_0100;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        SHIFT  = 2'd1,
        COMMIT = 2'd2
    } conv_state_e;

    function automatic logic [6:0] seg_decode(input logic [3:0] digit);
        logic [6:0] pattern;
        case (digit)
            4'd0:    pattern = SEG_0;
            4'd1:    pattern = SEG_1;
            4'd2:    pattern = SEG_2;
            4'd3:    pattern = SEG_3;
            4'd4:    pattern = SEG_4;
            4'd5:    pattern = SEG_5;
            4'd6:    pattern = SEG_6;
            4'd7:    pattern = SEG_7;
            4'd8:    pattern = SEG_8;
            4'd9:    pattern = SEG_9;
            default: pattern = SEG_BLANK;
        endcase
        return pattern;
    endfunction

    function automatic logic [13:0] saturate(input logic [13:0] value);
        return (value > MAX_SCORE) ? MAX_SCORE : value;
    endfunction

endpackage

// File: rtl/bin2bcd_seq.sv
// Sequential 14-bit binary to 4-digit BCD converter (shift-add-3).
//
// A start pulse in IDLE captures bin_in and runs one shift per input bit,
// MSB first, for 14 cycles, then spends one COMMIT cycle presenting the
// finished result with done=1. start is ignored while a conversion runs.
//
// Ports:
//   clk      system clock, rising edge
//   rst      synchronous active-high reset; aborts any conversion
//   start    one-cycle request to convert bin_in (honoured only in IDLE)
//   bin_in   binary value to convert; caller keeps it <= 9999
//   busy     high whenever the converter is not in IDLE
//   done     high during the COMMIT cycle; bcd_out is final then
//   bcd_out  BCD accumulator, digit 0 in bits [3:0]
module bin2bcd_seq
    import disp_pkg::*;
(
    input  logic        clk,
    input  logic        rst,
    input  logic        start,
    input  logic [13:0] bin_in,
    output logic        busy,
    output logic        done,
    output logic [15:0] bcd_out
);

    localparam logic [3:0] LAST_ITER = 4'd13;

    conv_state_e state_q, state_d;
    logic [13:0] bin_q,   bin_d;
    logic [15:0] bcd_q,   bcd_d;
    logic [3:0]  iter_q,  iter_d;

    // Every nibble that is 5 or more gets +3 before the shift, so the
    // doubling carries into the next decimal digit instead of leaving
    // a non-decimal value behind.
    logic [15:0] bcd_adj;

    for (genvar gi = 0; gi < NUM_DIGITS; gi++) begin : g_adj
        assign bcd_adj[4*gi +: 4] = (bcd_q[4*gi +: 4] >= 4'd5)
                                  ? bcd_q[4*gi +: 4] + 4'd3
                                  : bcd_q[4*gi +: 4];
    end

    always_comb begin
        state_d = state_q;
        bin_d   = bin_q;
        bcd_d   = bcd_q;
        iter_d  = iter_q;

        case (state_q)
            IDLE: begin
                if (start) begin
                    bin_d   = bin_in;
                    bcd_d   = '0;
                    iter_d  = '0;
                    state_d = SHIFT;
                end
            end

            SHIFT: begin
                // {bcd, bin} shifted left as one 30-bit register.
                bcd_d  = {bcd_adj[14:0], bin_q[13]};
                bin_d  = {bin_q[12:0], 1'b0};
                iter_d = iter_q + 4'd1;
                if (iter_q == LAST_ITER) begin
                    state_d = COMMIT;
                end
            end

            COMMIT: begin
                state_d = IDLE;
            end

            default: begin
                state_d = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
            bin_q   <= '0;
            bcd_q   <= '0;
            iter_q  <= '0;
        end else begin
            state_q <= state_d;
            bin_q   <= bin_d;
            bcd_q   <= bcd_d;
            iter_q  <= iter_d;
        end
    end

    assign busy    = (state_q != IDLE);
    assign done    = (state_q == COMMIT);
    assign bcd_out = bcd_q;

endmodule

// File: rtl/score_display_ctrl.sv
// Breakout score display controller for a 4-digit multiplexed
// seven-segment display.
//
// A score_load pulse hands the (saturated) score to the BCD converter.
// When the conversion commits, all four digit registers update at once.
// Independently, a refresh counter steps the scan index through the
// digits, and a registered output stage drives one anode at a time with
// the decoded segments. Leading zeros can optionally be blanked.
//
// Parameters:
//   REFRESH_CNT    clocks each digit stays selected (>= 2)
//   BLANK_LEADING  1 = dark leading zeros, 0 = always show four digits
//
// Ports:
//   clk         system clock, rising edge
//   rst         synchronous active-high reset
//   score_in    binary score, values above 9999 shown as 9999
//   score_load  one-cycle strobe capturing score_in (ignored while busy)
//   busy        high while a conversion is in progress
//   an          digit anodes, active low, an[0] = units digit
//   seg         segments, active low, {a,b,c,d,e,f,g}
//   dp          decimal point, active low, permanently off
module score_display_ctrl
    import disp_pkg::*;
#(
    parameter int REFRESH_CNT   = 100000,
    parameter bit BLANK_LEADING = 1'b1
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic [13:0]           score_in,
    input  logic                  score_load,
    output logic                  busy,
    output logic [NUM_DIGITS-1:0] an,
    output logic [6:0]            seg,
    output logic                  dp
);

    localparam int CNT_W = (REFRESH_CNT > 1) ? $clog2(REFRESH_CNT) : 1;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(REFRESH_CNT - 1);

    // ------------------------------------------------------------------
    // Converter
    // ------------------------------------------------------------------
    logic        conv_busy;
    logic        conv_done;
    logic [15:0] conv_bcd;

    bin2bcd_seq u_bin2bcd (
        .clk     (clk),
        .rst     (rst),
        .start   (score_load),
        .bin_in  (saturate(score_in)),
        .busy    (conv_busy),
        .done    (conv_done),
        .bcd_out (conv_bcd)
    );

    // ------------------------------------------------------------------
    // State
    // ------------------------------------------------------------------
    logic [4*NUM_DIGITS-1:0] digit_q,       digit_d;
    logic [CNT_W-1:0]        refresh_cnt_q, refresh_cnt_d;
    logic [1:0]              scan_idx_q,    scan_idx_d;
    logic [NUM_DIGITS-1:0]   an_q,          an_d;
    logic [6:0]              seg_q,         seg_d;

    // ------------------------------------------------------------------
    // Leading-zero detection: digit k is a leading zero when it and every
    // digit above it is zero. Each slot looks at its own upper slice so
    // there is no ripple chain between digits. Digit 0 always shows.
    // ------------------------------------------------------------------
    logic [NUM_DIGITS-1:0] digit_blank;

    for (genvar gi = 0; gi < NUM_DIGITS; gi++) begin : g_blank
        if (gi == 0) begin : g_units
            assign digit_blank[gi] = 1'b0;
        end else begin : g_upper
            assign digit_blank[gi] = BLANK_LEADING &&
                (digit_q[4*NUM_DIGITS-1 : 4*gi] == '0);
        end
    end

    logic [3:0] sel_digit;
    assign sel_digit = digit_q[4*scan_idx_q +: 4];

    always_comb begin
        digit_d       = digit_q;
        refresh_cnt_d = refresh_cnt_q;
        scan_idx_d    = scan_idx_q;
        an_d          = an_q;
        seg_d         = seg_q;

        // All four digits take the converter result in the same cycle so
        // the display never shows a half-updated score.
        if (conv_done) begin
            digit_d = conv_bcd;
        end

        if (refresh_cnt_q == CNT_LAST) begin
            refresh_cnt_d = '0;
            scan_idx_d    = scan_idx_q + 2'd1;
        end else begin
            refresh_cnt_d = refresh_cnt_q + CNT_W'(1);
        end

        // Output stage reflects the scan index and digits as they stand
        // this cycle; a commit coinciding with a scan wrap shows up on the
        // following registered output for the newly selected digit.
        if (digit_blank[scan_idx_q]) begin
            an_d  = '1;
            seg_d = SEG_BLANK;
        end else begin
            an_d  = ~(NUM_DIGITS'(1) << scan_idx_q);
            seg_d = seg_decode(sel_digit);
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            digit_q       <= '0;
            refresh_cnt_q <= '0;
            scan_idx_q    <= '0;
            an_q          <= '1;
            seg_q         <= SEG_BLANK;
        end else begin
            digit_q       <= digit_d;
            refresh_cnt_q <= refresh_cnt_d;
            scan_idx_q    <= scan_idx_d;
            an_q          <= an_d;
            seg_q         <= seg_d;
        end
    end

    assign busy = conv_busy;
    assign an   = an_q;
    assign seg  = seg_q;
    assign dp   = 1'b1;

endmodule
